alu_seq: RTL and testbench

- Parametrised multi-cycle ALU; successor to the fixed 16-bit add/sub/mul/logic unit.
- One FSM dispatches each accepted operation to one of three units: add/sub (1 cycle), logic (1 cycle), or an iterative shift-add multiplier (WIDTH cycles).
- Uses a cs/rdy request handshake plus a one-cycle done pulse.
- Produces a full 2*WIDTH product, plus carry, zero and error flags.

---
 rtl/alu_seq_pkg.sv | 40 ++++
 rtl/alu_seq_mul.sv | 64 ++++++
 rtl/alu_seq.sv | 177 +++++++++++++++++
 tb/tb_alu_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module  : alu_seq_pkg
// Purpose : Shared opcode and FSM state definitions for the sequential ALU.
//           Optional feature macro: ALU_SEQ_SIGNED_MUL_EN (op 3 = MULS).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  // Opcode encoding
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_MULS = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_NOT  = 3'd7;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC_AL  = 2'd1,
    EXEC_MUL = 2'd2,
    DONE     = 2'd3
  } state_t;

  // True for opcodes that run on the iterative multiplier
  function automatic logic is_mul_op(input logic [2:0] op);
`ifdef ALU_SEQ_SIGNED_MUL_EN
    return (op == OP_MUL) || (op == OP_MULS);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_mul.sv
// ============================================================================
// Module  : alu_seq_mul
// Purpose : Iterative shift-add unsigned multiplier, one partial product per
//           step. The caller owns sequencing via start/step and watches last.
//           prod_next is the product after the current step, so the caller
//           can capture the final result on the same edge the counter ends.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_mul #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 step,
  input  logic [WIDTH-1:0]     mcand_in,
  input  logic [WIDTH-1:0]     mplier_in,
  output logic                 last,
  output logic [2*WIDTH-1:0]   prod_next
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   sum;

  // Conditional add of the multiplicand into the upper half; carry kept
  always_comb begin
    sum = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
  end

  // {acc, mplier} after this step's add and right shift
  assign prod_next = {sum, mplier[WIDTH-1:1]};
  assign last      = (cnt == CNT_ONE);

  // Load on start, otherwise shift one bit per step until the counter empties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= mcand_in;
      acc    <= '0;
      mplier <= mplier_in;
      cnt    <= CNT_INIT;
    end else if (step && (cnt != '0)) begin
      acc    <= sum[WIDTH:1];
      mplier <= {sum[0], mplier[WIDTH-1:1]};
      cnt    <= cnt - CNT_ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module  : alu_seq
// Purpose : Multi-cycle ALU with cs/rdy request handshake and one-cycle done
//           pulse. Add/sub and logic complete in one cycle, multiply takes
//           WIDTH cycles and produces a full 2*WIDTH product.
//           Optional feature macro: ALU_SEQ_SIGNED_MUL_EN enables op 3 as a
//           two's-complement signed multiply (otherwise op 3 is illegal).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             rdy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             cout,
  output logic             zero,
  output logic             err
);

  state_t state;

  // Operands captured at accept
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;

  // Single-cycle datapath results
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   as_sum;
  logic [WIDTH-1:0] al_out;
  logic             al_cout;
  logic             al_err;

  // Multiplier interface
  logic               accept;
  logic               mul_start;
  logic               mul_step;
  logic               mul_last;
  logic [WIDTH-1:0]   mcand_in;
  logic [WIDTH-1:0]   mplier_in;
  logic [2*WIDTH-1:0] prod_next;
  logic [2*WIDTH-1:0] mul_res;

  assign accept    = cs && ((state == IDLE) || (state == DONE));
  assign mul_start = accept && is_mul_op(op);
  assign mul_step  = (state == EXEC_MUL);

`ifdef ALU_SEQ_SIGNED_MUL_EN
  logic is_muls;
  logic neg_q;

  // Signed multiply runs on operand magnitudes; the sign is restored at the end
  assign is_muls   = (op == OP_MULS);
  assign mcand_in  = (is_muls && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign mplier_in = (is_muls && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign mul_res   = neg_q ? (~prod_next + (2*WIDTH)'(1)) : prod_next;
`else
  assign mcand_in  = a;
  assign mplier_in = b;
  assign mul_res   = prod_next;
`endif

  alu_seq_mul #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (mul_start),
    .step      (mul_step),
    .mcand_in  (mcand_in),
    .mplier_in (mplier_in),
    .last      (mul_last),
    .prod_next (prod_next)
  );

  // Shared (WIDTH+1)-bit adder for ADD/SUB plus the bitwise logic ops
  always_comb begin
    b_eff   = (op_q == OP_SUB) ? ~b_q : b_q;
    as_sum  = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op_q == OP_SUB)};
    al_out  = '0;
    al_cout = 1'b0;
    al_err  = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        al_out  = as_sum[WIDTH-1:0];
        al_cout = as_sum[WIDTH];
      end
      OP_AND:  al_out = a_q & b_q;
      OP_OR:   al_out = a_q | b_q;
      OP_XOR:  al_out = a_q ^ b_q;
      OP_NOT:  al_out = ~a_q;
      default: al_err = 1'b1;
    endcase
  end

  // Sequencer: accepts requests, dispatches, and registers results and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rdy    <= 1'b1;
      done   <= 1'b0;
      out    <= '0;
      out_hi <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
      err    <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
`ifdef ALU_SEQ_SIGNED_MUL_EN
      neg_q  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (cs) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            rdy   <= 1'b0;
            state <= is_mul_op(op) ? EXEC_MUL : EXEC_AL;
`ifdef ALU_SEQ_SIGNED_MUL_EN
            neg_q <= (op == OP_MULS) && (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
          end else begin
            rdy   <= 1'b1;
            state <= IDLE;
          end
        end
        EXEC_AL: begin
          out    <= al_out;
          out_hi <= '0;
          cout   <= al_cout;
          zero   <= (al_out == '0);
          err    <= al_err;
          done   <= 1'b1;
          rdy    <= 1'b1;
          state  <= DONE;
        end
        EXEC_MUL: begin
          if (mul_last) begin
            out    <= mul_res[WIDTH-1:0];
            out_hi <= mul_res[2*WIDTH-1:WIDTH];
            cout   <= 1'b0;
            zero   <= (mul_res == '0);
            err    <= 1'b0;
            done   <= 1'b1;
            rdy    <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          rdy   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module  : tb_alu_seq
// Purpose : Self-checking bench for alu_seq (WIDTH=16): vector table plus
//           hand-written handshake, back-to-back and reset sequences.
//           Honours ALU_SEQ_SIGNED_MUL_EN for the op 3 expectation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W  = 16;
  localparam int NV = 14;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cs = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         rdy;
  logic         done;
  logic [W-1:0] out;
  logic [W-1:0] out_hi;
  logic         cout;
  logic         zero;
  logic         err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eo;
    logic [W-1:0] eh;
    logic         ec;
    logic         ez;
    logic         ee;
    int           lat;
  } vec_t;

  vec_t tbl [NV];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cs     (cs),
    .op     (op),
    .a      (a),
    .b      (b),
    .rdy    (rdy),
    .done   (done),
    .out    (out),
    .out_hi (out_hi),
    .cout   (cout),
    .zero   (zero),
    .err    (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Issue one request, then count cycles until done (bounded)
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat, output int rlow);
    @(negedge clk);
    cs = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    cs = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
    lat = 0; rlow = 0;
    while (!done && lat < 40) begin
      if (!rdy) rlow++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rlow, ndone;

    tbl[0]  = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1};
    tbl[1]  = '{OP_SUB, 16'h0005, 16'h0007, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    tbl[2]  = '{OP_SUB, 16'h0007, 16'h0005, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
    tbl[3]  = '{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0, 16};
    tbl[4]  = '{OP_AND, 16'hA5A5, 16'h0F0F, 16'h0505, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    tbl[5]  = '{OP_OR,  16'hA5A5, 16'h0F0F, 16'hAFAF, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    tbl[6]  = '{OP_XOR, 16'hA5A5, 16'hFFFF, 16'h5A5A, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    tbl[7]  = '{OP_NOT, 16'h1234, 16'hFFFF, 16'hEDCB, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    tbl[8]  = '{OP_MUL, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16};
    tbl[9]  = '{OP_MUL, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b0, 1'b0, 1'b0, 16};
    tbl[10] = '{OP_SUB, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1};
    tbl[11] = '{OP_ADD, 16'h1234, 16'h4321, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    tbl[12] = '{OP_MUL, 16'h8000, 16'h0002, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 16};
`ifdef ALU_SEQ_SIGNED_MUL_EN
    tbl[13] = '{OP_MULS, 16'hFFFE, 16'h0003, 16'hFFFA, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16};
`else
    tbl[13] = '{OP_MULS, 16'hFFFE, 16'h0003, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 1};
`endif

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_rdy",  64'(rdy), 64'd1);
    check("reset_done", 64'(done), 64'd0);
    check("reset_out",  64'({out_hi, out}), 64'd0);
    check("reset_flags", 64'({cout, zero, err}), 64'd0);

    // Vector table
    for (int i = 0; i < NV; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, rlow);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
      check($sformatf("v%0d_rdy_low", i), 64'(rlow), 64'(tbl[i].lat));
      check($sformatf("v%0d_out", i), 64'(out), 64'(tbl[i].eo));
      check($sformatf("v%0d_out_hi", i), 64'(out_hi), 64'(tbl[i].eh));
      check($sformatf("v%0d_cout", i), 64'(cout), 64'(tbl[i].ec));
      check($sformatf("v%0d_zero", i), 64'(zero), 64'(tbl[i].ez));
      check($sformatf("v%0d_err", i), 64'(err), 64'(tbl[i].ee));
      check($sformatf("v%0d_rdy_done", i), 64'(rdy), 64'd1);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
      check($sformatf("v%0d_out_hold", i), 64'(out), 64'(tbl[i].eo));
    end

    // cs asserted while multiplying is ignored
    @(negedge clk);
    cs = 1'b1; op = OP_MUL; a = 16'hFFFF; b = 16'hFFFF;
    @(negedge clk);
    cs = 1'b0; lat = 0;
    while (!done && lat < 40) begin
      cs = (lat >= 4 && lat < 8); op = OP_ADD; a = 16'h0001; b = 16'h0001;
      @(negedge clk);
      lat++;
    end
    cs = 1'b0;
    check("midmul_latency", 64'(lat), 64'd16);
    check("midmul_prod", 64'({out_hi, out}), 64'hFFFE0001);
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midmul_extra_done", 64'(ndone), 64'd0);

    // Back-to-back: new request issued during the DONE cycle
    run_op(OP_XOR, 16'hA5A5, 16'hFFFF, lat, rlow);
    check("b2b_xor_latency", 64'(lat), 64'd1);
    check("b2b_xor_out", 64'(out), 64'h5A5A);
    check("b2b_rdy_in_done", 64'(rdy), 64'd1);
    cs = 1'b1; op = OP_AND; a = 16'hA5A5; b = 16'hFFFF;
    @(negedge clk);
    cs = 1'b0;
    check("b2b_accepted", 64'({done, rdy}), 64'd0);
    @(negedge clk);
    check("b2b_and_done", 64'(done), 64'd1);
    check("b2b_and_out", 64'(out), 64'hA5A5);

    // Reset during a multiply aborts it
    @(negedge clk);
    cs = 1'b1; op = OP_MUL; a = 16'hFFFF; b = 16'hFFFF;
    @(negedge clk);
    cs = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_out", 64'({out_hi, out}), 64'd0);
    check("rstmid_flags", 64'({cout, zero, err}), 64'd0);
    check("rstmid_rdy", 64'(rdy), 64'd1);
    check("rstmid_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rstmid_no_done", 64'(ndone), 64'd0);
    run_op(OP_ADD, 16'd3, 16'd4, lat, rlow);
    check("post_rst_latency", 64'(lat), 64'd1);
    check("post_rst_out", 64'(out), 64'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
